// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory request, 2-entry {pc, instr}
// buffer towards decode, branch flush support.
// Optional build macro IFETCH_PERF_CNT_EN adds the 32-bit fetch_count output.
//
// state | meaning
// IDLE  | no request; waits for a free buffer slot and no flush
// REQ   | imem_req held with imem_addr = pc until granted
// WAIT  | one request granted, waiting for its response
// DROP  | request in flight was flushed; swallow its response

`ifndef PC_ADDR_WIDTH
`define PC_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ifetch #(
  parameter int AW = `PC_ADDR_WIDTH,
  parameter int IW = `DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_advance,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        tag_q;
  logic                 tag_load;
  logic [1:0][AW-1:0]   fifo_pc_q;
  logic [1:0][IW-1:0]   fifo_data_q;
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  logic                 push, pop;

  // Buffer head is presented straight to decode; flush wins over a handshake.
  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign pop         = instr_valid & instr_ready & ~flush;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    imem_addr  = '0;
    pc_advance = 1'b0;
    tag_load   = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Nothing is outstanding here, so only buffer occupancy matters.
        if (!flush && count_q != 2'd2) state_d = S_REQ;
      end
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_gnt) begin
          // A grant in the flush cycle is still in flight and must be drained.
          pc_advance = 1'b1;
          tag_load   = 1'b1;
          state_d    = flush ? S_DROP : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            push = 1'b1;
            // Buffer holds at most one entry here; after this push a slot
            // stays free if it was empty or its head leaves this cycle.
            state_d = (count_q == 2'd0 || pop) ? S_REQ : S_IDLE;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address tag of the request in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        tag_q <= '0;
    else if (tag_load) tag_q <= pc;
  end

  // Two-entry {pc, instruction} buffer; flush empties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_pc_q   <= '0;
      fifo_data_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= tag_q;
        fifo_data_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Counts instructions actually accepted by decode; survives flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory responder, pc register and a scoreboard of
// granted-but-undelivered fetch addresses, driven by directed phases and
// randomized traffic.
module tb_ifetch;
  localparam int AW = 16;
  localparam int IW = 32;

  logic          clock, reset;
  logic [AW-1:0] pc;
  logic          pc_advance, flush, imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt, imem_rvalid;
  logic [IW-1:0] imem_rdata, instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid, instr_ready;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]   fetch_count;
`endif

  ifetch #(.AW(AW), .IW(IW)) dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    bit            live;
  } pend_t;

  pend_t         pend[$];
  logic [AW-1:0] expq[$];
  logic [AW-1:0] delivered[$];
  logic [AW-1:0] pc_m, flush_target, force_target, last_grant_addr, pc_r;
  logic [31:0]   fcount;
  int cyc, checks, errors;
  int gnt_pct, ready_pct, flush_pct, lat_min, lat_max;
  int n0;
  bit force_flush, flush_on_rv, hit, last_grant, exp_valid_next, prev_hold;
  logic [AW-1:0] prev_pc;

  function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {16'h0, a} * 32'h9E3779B1;
    return t ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    foreach (pend[i]) pend[i].live = 1'b0;
    fcount = '0;
    prev_hold = 1'b0;
    exp_valid_next = 1'b0;
  endtask

  task automatic drive_inputs();
    pc          = pc_m;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    instr_ready = ($urandom_range(0, 99) < ready_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(pend[0].addr);
    end
    flush = force_flush || ($urandom_range(0, 99) < flush_pct);
    flush_target = force_flush ? force_target : AW'($urandom_range(0, 255));
    if (flush_on_rv && instr_valid && imem_rvalid) begin
      flush       = 1'b1;
      instr_ready = 1'b1;
      hit         = 1'b1;
    end
    force_flush = 1'b0;
  endtask

  task automatic observe_and_model();
    bit gr, hs;
    int lat;
    gr = imem_req && imem_gnt;
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, fcount);
`endif
    if (exp_valid_next) begin
      chk("latency_valid", instr_valid, 1'b1);
      exp_valid_next = 1'b0;
    end
    if (prev_hold) begin
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_pc", instr_pc, prev_pc);
    end
    if (imem_req) chk("req_addr", imem_addr, pc_m);
    chk("pc_advance", pc_advance, gr);
    if (instr_valid) begin
      chk("head_known", expq.size() > 0, 1'b1);
      if (expq.size() > 0) begin
        chk("instr_pc", instr_pc, expq[0]);
        chk("instr", instr, mdata(expq[0]));
      end
    end
    if (imem_rvalid) begin
      if (pend[0].live && !flush && !instr_valid) exp_valid_next = 1'b1;
      void'(pend.pop_front());
    end
    hs = instr_valid && instr_ready && !flush;
    if (hs && expq.size() > 0) begin
      delivered.push_back(expq.pop_front());
      fcount = fcount + 32'd1;
    end
    if (gr) begin
      chk("one_outstanding", 64'(pend.size()), 64'd0);
      lat = $urandom_range(lat_min, lat_max);
      pend.push_back('{imem_addr, cyc + lat, !flush});
      if (!flush) expq.push_back(imem_addr);
      last_grant      = 1'b1;
      last_grant_addr = imem_addr;
    end
    if (flush) begin
      expq.delete();
      foreach (pend[i]) pend[i].live = 1'b0;
    end
    pc_m      = flush ? flush_target : (gr ? pc_m + AW'(1) : pc_m);
    prev_hold = instr_valid && !instr_ready && !flush;
    prev_pc   = instr_pc;
    chk("buffer_bound", expq.size() <= 2, 1'b1);
  endtask

  task automatic step();
    drive_inputs();
    #1;
    observe_and_model();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_imem_req"}, imem_req, 1'b0);
    chk({pfx, "_pc_advance"}, pc_advance, 1'b0);
    chk({pfx, "_instr_valid"}, instr_valid, 1'b0);
    chk({pfx, "_instr"}, instr, '0);
    chk({pfx, "_instr_pc"}, instr_pc, '0);
    chk({pfx, "_imem_addr"}, imem_addr, '0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    pc_m = '0; fcount = '0; force_flush = 0; flush_on_rv = 0; hit = 0;
    last_grant = 0; exp_valid_next = 0; prev_hold = 0; prev_pc = '0;
    // Reset held with busy-looking inputs: everything must stay quiet.
    reset = 1'b0; pc = 16'h0007; flush = 1'b0; imem_gnt = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = '1; instr_ready = 1'b1;
    #7;
    check_outputs_zero("rst");
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1; imem_rvalid = 1'b0;

    // Zero-wait memory, decode always ready: pc 0,1,2 delivered in order.
    gnt_pct = 100; ready_pct = 100; flush_pct = 0; lat_min = 1; lat_max = 1;
    repeat (20) step();
    chk("a_count", delivered.size() >= 3, 1'b1);
    if (delivered.size() >= 3) begin
      chk("a_pc0", delivered[0], 16'd0);
      chk("a_pc1", delivered[1], 16'd1);
      chk("a_pc2", delivered[2], 16'd2);
    end

    // Decode stalls: buffer fills to two, requests stop, then drains.
    ready_pct = 0;
    repeat (6) step();
    chk("b_imem_req", imem_req, 1'b0);
    chk("b_valid", instr_valid, 1'b1);
    chk("b_buffered", 64'(expq.size()), 64'd2);
    ready_pct = 100;
    n0 = delivered.size();
    repeat (10) step();
    chk("b_resume", delivered.size() >= n0 + 3, 1'b1);

    // Grant withheld with pc=5: address stays put, no pc_advance.
    gnt_pct = 0;
    repeat (4) step();
    force_flush = 1'b1; force_target = 16'd5;
    step();
    step();
    repeat (3) begin
      chk("c_imem_req", imem_req, 1'b1);
      chk("c_imem_addr", imem_addr, 16'd5);
      step();
    end
    gnt_pct = 100;
    n0 = delivered.size();
    repeat (6) step();
    chk("c_delivered", delivered.size() > n0, 1'b1);
    if (delivered.size() > n0) chk("c_first_pc", delivered[n0], 16'd5);

    // Flush while waiting on the fetch of 3, branch to 19.
    gnt_pct = 0; lat_min = 3; lat_max = 3;
    force_flush = 1'b1; force_target = 16'd3;
    step();
    gnt_pct = 100; last_grant = 0;
    for (int i = 0; i < 12 && !last_grant; i++) step();
    chk("d_grant_seen", last_grant, 1'b1);
    chk("d_tag", last_grant_addr, 16'd3);
    force_flush = 1'b1; force_target = 16'd19;
    step();
    chk("d_drop_no_req", imem_req, 1'b0);
    n0 = delivered.size();
    repeat (14) step();
    chk("d_delivered", delivered.size() > n0, 1'b1);
    if (delivered.size() > n0) chk("d_first_pc", delivered[n0], 16'd19);

    // Flush coinciding with a decode handshake and a response.
    lat_min = 2; lat_max = 2; ready_pct = 0; hit = 0; flush_on_rv = 1;
    n0 = delivered.size();
    for (int i = 0; i < 40 && !hit; i++) step();
    flush_on_rv = 0;
    chk("e_hit", hit, 1'b1);
    chk("e_empty", instr_valid, 1'b0);
    chk("e_not_counted", 64'(delivered.size()), 64'(n0));
    ready_pct = 100;

    // Randomized traffic.
    for (int blk = 0; blk < 25; blk++) begin
      gnt_pct   = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      flush_pct = $urandom_range(0, 10);
      lat_min   = 1;
      lat_max   = $urandom_range(1, 4);
      repeat (100) step();
    end
    chk("f_progress", delivered.size() > 200, 1'b1);

    // Reset in the middle of a fetch; its late response must be ignored.
    gnt_pct = 100; ready_pct = 100; flush_pct = 0; lat_min = 5; lat_max = 5;
    last_grant = 0;
    for (int i = 0; i < 20 && !last_grant; i++) step();
    chk("g_grant_seen", last_grant, 1'b1);
    pc_r = pc_m;
    reset = 1'b0;
    #1;
    check_outputs_zero("g");
`ifdef IFETCH_PERF_CNT_EN
    chk("g_fetch_count", fetch_count, 32'd0);
`endif
    model_reset();
    gnt_pct = 0;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 20 && pend.size() > 0; i++) step();
    chk("g_stray_gone", 64'(pend.size()), 64'd0);
    step();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    n0 = delivered.size();
    repeat (12) step();
    chk("g_delivered", delivered.size() > n0, 1'b1);
    if (delivered.size() > n0) chk("g_restart_pc", delivered[n0], pc_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
